// File: rtl/xoro_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package xoro_bus_pkg;

  // Arbiter FSM encoding; value 3 is unused and treated as idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // Read data handed back to a master whose transfer timed out.
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

  // Width of the slave-ready wait counter; bounds the timeout to 255 cycles.
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single memory-bus port: valid/instr/addr/wdata/wstrb request, ready/rdata response.
// Latency: none (wires only).
// Backpressure: requester holds valid until it sees a one-cycle ready pulse.
interface mem_arbiter_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Side that issues requests (a CPU or DMA, or the arbiter toward the slave).
  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Side that answers requests (the memory, or the arbiter toward a master).
  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/arb_wait_timer.sv
// Counts granted cycles spent waiting for slave ready and flags the terminal count.
// Latency: tc reflects the registered count, i.e. one cycle after each increment.
// Backpressure: none; clr has priority over inc.
module arb_wait_timer
  import xoro_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [WAIT_CNT_W-1:0] TC_VAL = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  // Clear while idle so every grant starts from zero; otherwise count stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory bus arbiter with slave-ready timeout (ARB_ROUND_ROBIN_EN: round-robin ties).
// Latency: grant one cycle after valid is seen idle; ready/rdata pass through combinationally.
// Backpressure: granted master waits on s ready; after TIMEOUT-1 stalls it gets ERR_RDATA and timeout_err.
module mem_arbiter
  import xoro_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  mem_arbiter_if.slave         m0,
  mem_arbiter_if.slave         m1,
  mem_arbiter_if.master        s,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic gnt0;
  logic gnt1;
  logic own_vld;
  logic own_rdy;
  logic to_hit;
  logic tmr_tc;

  assign gnt0    = (state_q == ST_GNT0);
  assign gnt1    = (state_q == ST_GNT1);
  // Valid of whichever master currently owns the bus.
  assign own_vld = (gnt0 & m0.mem_valid) | (gnt1 & m1.mem_valid);
  // Ready is only forwarded to an owner that is still requesting.
  assign own_rdy = own_vld & s.mem_ready;
  // Slave response beats the timeout when both land in the same cycle.
  assign to_hit  = own_vld & ~s.mem_ready & tmr_tc;

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state_q == ST_IDLE),
    .inc    ((gnt0 | gnt1) & ~s.mem_ready),
    .tc     (tmr_tc)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // 0: m0 owned the bus last, 1: m1 did; reset to 1 so m0 wins the first tie.
  logic last_q;
  logic last_d;

  // Remember the owner of every new grant.
  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      last_d = (state_d == ST_GNT1);
    end
  end

  // Last-owner register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant from idle only; a granted transfer ends on ready, timeout or dropped valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0.mem_valid && m1.mem_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_q ? ST_GNT0 : ST_GNT1;
`else
          state_d = ST_GNT0;
`endif
        end else if (m0.mem_valid) begin
          state_d = ST_GNT0;
        end else if (m1.mem_valid) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!own_vld || s.mem_ready || tmr_tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Route the owner's request to the slave and the slave's response back; all zero when idle.
  always_comb begin
    s.mem_valid  = 1'b0;
    s.mem_instr  = 1'b0;
    s.mem_addr   = 32'h0;
    s.mem_wdata  = 32'h0;
    s.mem_wstrb  = 4'h0;
    m0.mem_ready = 1'b0;
    m0.mem_rdata = 32'h0;
    m1.mem_ready = 1'b0;
    m1.mem_rdata = 32'h0;
    grant        = 2'b00;
    timeout_err  = to_hit;
    case (state_q)
      ST_GNT0: begin
        grant        = 2'b01;
        s.mem_valid  = m0.mem_valid & ~to_hit;
        s.mem_instr  = m0.mem_instr;
        s.mem_addr   = m0.mem_addr;
        s.mem_wdata  = m0.mem_wdata;
        s.mem_wstrb  = m0.mem_wstrb;
        m0.mem_ready = own_rdy | to_hit;
        m0.mem_rdata = to_hit ? ERR_RDATA : s.mem_rdata;
      end
      ST_GNT1: begin
        grant        = 2'b10;
        s.mem_valid  = m1.mem_valid & ~to_hit;
        s.mem_instr  = m1.mem_instr;
        s.mem_addr   = m1.mem_addr;
        s.mem_wdata  = m1.mem_wdata;
        s.mem_wstrb  = m1.mem_wstrb;
        m1.mem_ready = own_rdy | to_hit;
        m1.mem_rdata = to_hit ? ERR_RDATA : s.mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
